// File: rtl/alu_exec.sv
// Multi-cycle integer ALU: single-cycle arith/logic/shift, iterative mult/div.
// Define ALU_DIV_EN to build the restoring divider (code 0011).
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
`ifdef ALU_DIV_EN
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   rem_t;
  logic [WIDTH:0]   dif_t;
`endif

  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH:0]   mul_t;

  assign add_s = op_a + op_b;
  assign sub_s = op_a - op_b;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    mul_t   = '0;
`ifdef ALU_DIV_EN
    div_d   = div_q;
    dz_d    = dz_q;
    rem_t   = '0;
    dif_t   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = '0;
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
`ifdef ALU_DIV_EN
          dz_d    = 1'b0;
          div_d   = 1'b0;
`endif
          unique case (ALU_control)
            4'b0000: begin
              lo_d  = add_s;
              ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (add_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0001: begin
              lo_d  = sub_s;
              ovf_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0010: begin
              state_d = BUSY;
              lo_d    = op_b;
              b_d     = op_a;
            end
`ifdef ALU_DIV_EN
            4'b0011: begin
              if (op_b == '0) begin
                lo_d = '1;
                hi_d = op_a;
                dz_d = 1'b1;
              end else begin
                state_d = BUSY;
                div_d   = 1'b1;
                lo_d    = op_a;
                b_d     = op_b;
              end
            end
`endif
            4'b0100: lo_d = op_b << shamt;
            4'b0101: lo_d = op_b >> shamt;
            4'b1000: lo_d = op_a & op_b;
            4'b1001: lo_d = op_a | op_b;
            4'b1010: lo_d = op_a ^ op_b;
            4'b1011: lo_d = ~(op_a | op_b);
            default: begin
              lo_d  = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
`ifdef ALU_DIV_EN
        if (div_q) begin
          // restoring step: borrow out of the trial subtract means "keep"
          rem_t = {hi_q, lo_q[WIDTH-1]};
          dif_t = rem_t - {1'b0, b_q};
          if (!dif_t[WIDTH]) begin
            hi_d = dif_t[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_t[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          mul_t        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
          {hi_d, lo_d} = {mul_t, lo_q[WIDTH-1:1]};
        end
`else
        mul_t        = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        {hi_d, lo_d} = {mul_t, lo_q[WIDTH-1:1]};
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_DIV_EN
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
`ifdef ALU_DIV_EN
      div_q   <= div_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign zero      = out_valid && (lo_q == '0);
  assign ovf       = out_valid && ovf_q;
  assign illegal   = out_valid && ill_q;
`ifdef ALU_DIV_EN
  assign div0      = out_valid && dz_q;
`else
  assign div0      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table plus hold,
// back-pressure and mid-operation reset sequences.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALU_control = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        zero;
  logic        ovf;
  logic        div0;
  logic        illegal;

  alu_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALU_control(ALU_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .zero       (zero),
    .ovf        (ovf),
    .div0       (div0),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        v;
    logic        d;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       output int lat);
    @(negedge clk);
    ALU_control = ctl;
    op_a = a;
    op_b = b;
    shamt = sh;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = ~a;
    op_b = ~b;
    shamt = ~sh;
    ALU_control = 4'b1111;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("zero_gated", zero, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [31:0] hold_lo;
    logic [31:0] hold_hi;

    vq.push_back('{4'h0, 32'h7FFFFFFF, 32'h1, 5'd0,
                   32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vq.push_back('{4'h0, 32'hFFFFFFFF, 32'h1, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h1, 32'h80000000, 32'h1, 5'd0,
                   32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vq.push_back('{4'h1, 32'h5, 32'h5, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h2, 32'hFFFFFFFF, 32'h2, 5'd0,
                   32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 33});
    vq.push_back('{4'h2, 32'h00012345, 32'h00010000, 5'd0,
                   32'h23450000, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 33});
    vq.push_back('{4'h4, 32'h0, 32'h1, 5'd31,
                   32'h80000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h5, 32'h0, 32'h80000000, 5'd31,
                   32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h4, 32'h0, 32'hA5, 5'd0,
                   32'hA5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h8, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,
                   32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h9, 32'h0F0F0000, 32'h000000F0, 5'd0,
                   32'h0F0F00F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'hA, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,
                   32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'hB, 32'h0, 32'h0, 5'd0,
                   32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'hB, 32'hFFFF0000, 32'h0000FFFF, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{4'h6, 32'h12345678, 32'h9, 5'd3,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{4'hF, 32'h1, 32'h1, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
`ifdef ALU_DIV_EN
    vq.push_back('{4'h3, 32'd100, 32'd7, 5'd0,
                   32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33});
    vq.push_back('{4'h3, 32'd5, 32'd0, 5'd0,
                   32'hFFFFFFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vq.push_back('{4'h3, 32'hFFFFFFFF, 32'h10, 5'd0,
                   32'h0FFFFFFF, 32'hF, 1'b0, 1'b0, 1'b0, 1'b0, 33});
`else
    vq.push_back('{4'h3, 32'd100, 32'd7, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1});
`endif

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_div0", div0, 0);
    chk("rst_illegal", illegal, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    foreach (vq[i]) begin
      issue(vq[i].ctl, vq[i].a, vq[i].b, vq[i].sh, lat);
      chk($sformatf("v%0d_lat", i), lat, vq[i].lat);
      chk($sformatf("v%0d_lo", i), result_lo, vq[i].lo);
      chk($sformatf("v%0d_hi", i), result_hi, vq[i].hi);
      chk($sformatf("v%0d_zero", i), zero, vq[i].z);
      chk($sformatf("v%0d_ovf", i), ovf, vq[i].v);
      chk($sformatf("v%0d_div0", i), div0, vq[i].d);
      chk($sformatf("v%0d_ill", i), illegal, vq[i].il);
      drain();
    end

    // back-pressure: result must hold and new requests must be ignored
    issue(4'h2, 32'd3, 32'd4, 5'd0, lat);
    chk("hold_lat", lat, 33);
    hold_lo = 32'd12;
    hold_hi = 32'd0;
    ALU_control = 4'h0;
    op_a = 32'd1;
    op_b = 32'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_ready", k), in_ready, 0);
      chk($sformatf("hold%0d_lo", k), result_lo, hold_lo);
      chk($sformatf("hold%0d_hi", k), result_hi, hold_hi);
    end
    in_valid = 1'b0;
    drain();
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("hold_no_ghost", seen, 0);

    // reset at BUSY cycle 10 of a multiply
    @(negedge clk);
    ALU_control = 4'h2;
    op_a = 32'd9;
    op_b = 32'd9;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_ready", in_ready, 0);
    resetn = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_idle", in_ready, 1);
    chk("abort_lo", result_lo, 0);
    chk("abort_hi", result_hi, 0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    issue(4'h0, 32'd2, 32'd3, 5'd0, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_lo", result_lo, 5);
    chk("post_rst_ovf", ovf, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
